// File: rtl/kw11p_pkg.sv
// kw11p_pkg: shared register offsets, CSR bit positions, RATE codes and ident word
package kw11p_pkg;
  localparam logic [1:0] OFF_CSR = 2'd0;
  localparam logic [1:0] OFF_CSB = 2'd1;
  localparam logic [1:0] OFF_CTR = 2'd2;
  localparam int CSR_ERR    = 15;
  localparam int CSR_DONE   = 7;
  localparam int CSR_IE     = 6;
  localparam int CSR_FIX    = 5;
  localparam int CSR_UP     = 4;
  localparam int CSR_REPEAT = 3;
  localparam int CSR_RATE   = 1;
  localparam int CSR_RUN    = 0;
  typedef enum logic [1:0] {
    RATE_100K = 2'b00,
    RATE_10K  = 2'b01,
    RATE_LINE = 2'b10,
    RATE_EXT  = 2'b11
  } rate_e;
  localparam logic [31:0] IDENT = 32'h4B571001;
endpackage

// File: rtl/kw11p_if.sv
// kw11p_if: Unibus-style slave bus (address, control, data, INIT, MSYN in; data, SSYN out)
interface kw11p_if;
  logic [17:0] a_in_h;
  logic [1:0]  c_in_h;
  logic [15:0] d_in_h;
  logic        init_in_h;
  logic        msyn_in_h;
  logic [15:0] d_out_h;
  logic        ssyn_out_h;
  modport master (output a_in_h, c_in_h, d_in_h, init_in_h, msyn_in_h, input d_out_h, ssyn_out_h);
  modport slave (input a_in_h, c_in_h, d_in_h, init_in_h, msyn_in_h, output d_out_h, ssyn_out_h);
endinterface

// File: rtl/kw11p_intreq.sv
// kw11p_intreq: level-to-request interrupt helper
// Ports: clk/rst; rqst level in; intreq/irvec out; intgnt/igvec grant in.
// Once granted, the request stays down until rqst itself drops.
module kw11p_intreq #(
  parameter logic [7:0] VEC = 8'o104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rqst,
  input  logic       intgnt,
  input  logic [7:0] igvec,
  output logic       intreq,
  output logic [7:0] irvec
);
  logic intreq_q, intreq_d, acked_q, acked_d;
  always_comb begin
    acked_d = rqst & (acked_q | (intreq_q & intgnt & (igvec == VEC)));
    intreq_d = rqst & ~acked_d;
    intreq = intreq_q;
    irvec = intreq_q ? VEC : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      intreq_q <= 1'b0;
      acked_q <= 1'b0;
    end else begin
      intreq_q <= intreq_d;
      acked_q <= acked_d;
    end
  end
endmodule

// File: rtl/kw11p.sv
// kw11p: KW11-P programmable real-time clock (CSR, CSB, CTR) on a Unibus-style slave
// Ports: CLOCK/RESET; ARM side armwrite/armraddr/armwaddr/armwdata/armrdata;
// extclk count source; intreq/irvec/intgnt/igvec interrupt; bus slave interface.
module kw11p import kw11p_pkg::*; #(
  parameter int          CLKHZ   = 100000000,
  parameter int          LINEHZ  = 60,
  parameter logic [17:0] CSRADDR = 18'o772540,
  parameter logic [7:0]  INTVEC  = 8'o104
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic        armraddr,
  input  logic        armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        extclk,
  output logic        intreq,
  output logic [7:0]  irvec,
  input  logic        intgnt,
  input  logic [7:0]  igvec,
  kw11p_if.slave      bus
);
  localparam int PRE = CLKHZ / 100000;
  localparam int LINE = CLKHZ / LINEHZ;
  localparam int PW = $clog2(PRE + 1);
  localparam int LW = $clog2(LINE + 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0] dec_q, dec_d;
  logic [LW-1:0] line_q, line_d;
  logic enable_q, enable_d, ext_q, ext_d, err_q, err_d, done_q, done_d, ssyn_q, ssyn_d;
  logic [6:0] ctl_q, ctl_d, ctl_w;
  logic [15:0] csb_q, csb_d, ctr_q, ctr_d, dout_q, dout_d, csb_w, cnt_nxt, csr_word;
  logic [1:0] off;
  logic clr, tick100, tick10, tick_line, tick, hit, acc, wr, rd, csr_wr, csb_wr, csr_rd, cnt_ev, ovf;
  logic unused_ok;
  assign unused_ok = ^armwdata[30:0];
  always_comb begin
    clr = RESET | bus.init_in_h;
    tick100 = pre_q == PW'(PRE - 1);
    tick10 = tick100 & (dec_q == 4'd9);
    tick_line = line_q == LW'(LINE - 1);
    pre_d = tick100 ? '0 : pre_q + 1'b1;
    dec_d = tick10 ? 4'd0 : dec_q + {3'd0, tick100};
    line_d = tick_line ? '0 : line_q + 1'b1;
    ext_d = extclk;
    tick = ctl_q[CSR_RATE +: 2] == RATE_100K ? tick100 :
           ctl_q[CSR_RATE +: 2] == RATE_10K  ? tick10 :
           ctl_q[CSR_RATE +: 2] == RATE_LINE ? tick_line : extclk & ~ext_q;
    off = bus.a_in_h[2:1];
    hit = (bus.a_in_h[17:3] == CSRADDR[17:3]) && (off != 2'd3);
    // SSYN low gates the start so a held MSYN yields exactly one access
    acc = enable_q & bus.msyn_in_h & hit & ~ssyn_q;
    wr = acc & bus.c_in_h[1];
    rd = acc & ~bus.c_in_h[1];
    csr_wr = wr & (off == OFF_CSR) & ~(bus.c_in_h[0] & bus.a_in_h[0]);
    csb_wr = wr & (off == OFF_CSB);
    csr_rd = rd & (off == OFF_CSR);
    csb_w = ~bus.c_in_h[0] ? bus.d_in_h :
            bus.a_in_h[0] ? {bus.d_in_h[15:8], csb_q[7:0]} : {csb_q[15:8], bus.d_in_h[7:0]};
    ctl_w = csr_wr ? bus.d_in_h[6:0] & 7'b1011111 : ctl_q;
    // a tick needs RUN both before and after any same-cycle CSR write
    cnt_ev = ~csb_wr & ((tick & ctl_q[CSR_RUN] & ctl_w[CSR_RUN]) |
             (csr_wr & bus.d_in_h[CSR_FIX] & ~bus.d_in_h[CSR_RUN]));
    cnt_nxt = ctl_w[CSR_UP] ? ctr_q + 1'b1 : ctr_q - 1'b1;
    ovf = cnt_ev & (cnt_nxt == 16'd0);
    ctl_d = {ctl_w[6:1], ctl_w[CSR_RUN] & ~(ovf & ~ctl_w[CSR_REPEAT])};
    // overflow wins over the read-clear; ERR then keeps its old value
    done_d = ovf | (done_q & ~csr_rd);
    err_d = ovf ? err_q | (done_q & ~csr_rd) : err_q & ~csr_rd;
    ctr_d = csb_wr ? csb_w : ovf ? (ctl_w[CSR_REPEAT] ? csb_q : 16'd0) : cnt_ev ? cnt_nxt : ctr_q;
    csb_d = csb_wr ? csb_w : csb_q;
    csr_word = {err_q, 7'd0, done_q, ctl_q};
    dout_d = rd ? (off == OFF_CSR ? csr_word : off == OFF_CTR ? ctr_q : 16'd0) :
             bus.msyn_in_h ? dout_q : 16'd0;
    ssyn_d = acc | (ssyn_q & bus.msyn_in_h);
    enable_d = (armwrite & armwaddr) ? armwdata[31] : enable_q;
    armrdata = armraddr ? {enable_q, err_q, 6'd0, csr_word[7:0], ctr_q} : IDENT;
    bus.d_out_h = dout_q;
    bus.ssyn_out_h = ssyn_q;
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      enable_q <= 1'b0;
      pre_q <= '0;
      dec_q <= 4'd0;
      line_q <= '0;
    end else begin
      enable_q <= enable_d;
      pre_q <= pre_d;
      dec_q <= dec_d;
      line_q <= line_d;
    end
  end
  always_ff @(posedge CLOCK) begin
    if (clr) begin
      ext_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      ctl_q <= 7'd0;
      csb_q <= 16'd0;
      ctr_q <= 16'd0;
      dout_q <= 16'd0;
      ssyn_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      err_q <= err_d;
      done_q <= done_d;
      ctl_q <= ctl_d;
      csb_q <= csb_d;
      ctr_q <= ctr_d;
      dout_q <= dout_d;
      ssyn_q <= ssyn_d;
    end
  end
  kw11p_intreq #(.VEC(INTVEC)) u_intreq (
    .clk(CLOCK),
    .rst(clr),
    .rqst(done_q & ctl_q[CSR_IE]),
    .intgnt(intgnt),
    .igvec(igvec),
    .intreq(intreq),
    .irvec(irvec)
  );
endmodule
